// File: rtl/sched_pkg.sv
// Shared definitions for the register-hazard scheduler.
// These cover the register file geometry, the default pending-counter width and the x0 helper.
package sched_pkg;

  localparam int REG_NUM       = 32;
  localparam int REG_IDX_W     = 5;
  localparam int DEFAULT_CNT_W = 2;

  localparam logic [REG_IDX_W-1:0] X0_IDX = '0;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // x0 is hardwired to zero, so it never carries a pending write.
  function automatic logic is_arch_reg(input reg_idx_t idx);
    return idx != X0_IDX;
  endfunction

endpackage

// File: rtl/sb_reg_counter.sv
// Pending-write counter for one architectural register.
// It counts up on issue and down on writeback, and both saturate.
// A decrement at zero holds the count and raises underflow for that cycle.
module sb_reg_counter #(
  parameter int CNT_W = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic inc,
  input  logic dec,
  output logic busy,
  output logic full,
  output logic underflow
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, a simultaneous inc/dec cancels, and both directions saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc) begin
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign busy      = (cnt_q != '0);
  assign full      = (cnt_q == '1);
  assign underflow = dec && !inc && !clear && (cnt_q == '0);

endmodule

// File: rtl/issue_scoreboard.sv
// Register-hazard scheduler for the first schedule stage.
// It tracks outstanding writes to x1..x31 and decides each cycle whether the
// decoded instruction may issue. When it may not, it drives STALL to the
// decode/schedule pipeline registers.
module issue_scoreboard
  import sched_pkg::*;
#(
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   FLUSH,
  input  logic                   MEM_WAIT,
  input  logic                   ISSUE_VALID,
  input  logic [REG_IDX_W-1:0]   ISSUE_RS1,
  input  logic                   ISSUE_RS1_USE,
  input  logic [REG_IDX_W-1:0]   ISSUE_RS2,
  input  logic                   ISSUE_RS2_USE,
  input  logic [REG_IDX_W-1:0]   ISSUE_RD,
  input  logic                   ISSUE_RD_WRITE,
  input  logic                   WB_VALID,
  input  logic [REG_IDX_W-1:0]   WB_RD,
  output logic                   ISSUE_ACCEPT,
  output logic                   STALL,
  output logic [REG_NUM-1:0]     BUSY_VEC,
  output logic                   ERR_UNDERFLOW,
  output logic [STALL_CNT_W-1:0] STALL_CNT
);

  logic [REG_NUM-1:0] busy_vec;
  logic [REG_NUM-1:0] full_vec;
  logic [REG_NUM-1:0] uf_vec;

  logic raw1;
  logic raw2;
  logic sat;
  logic hazard;
  logic issue_accept;
  logic stall;
  logic inc_en;
  logic dec_en;

  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic [STALL_CNT_W-1:0] stall_cnt_d;
  logic                   err_q;
  logic                   err_d;

  // x0 has no counter, so its slot always reads as idle.
  assign busy_vec[0] = 1'b0;
  assign full_vec[0] = 1'b0;
  assign uf_vec[0]   = 1'b0;

  genvar i;
  for (i = 1; i < REG_NUM; i++) begin : g_cnt
    sb_reg_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .CLK       (CLK),
      .RST       (RST),
      .clear     (FLUSH),
      .inc       (inc_en && (ISSUE_RD == REG_IDX_W'(i))),
      .dec       (dec_en && (WB_RD == REG_IDX_W'(i))),
      .busy      (busy_vec[i]),
      .full      (full_vec[i]),
      .underflow (uf_vec[i])
    );
  end

  // Hazard detection uses registered counters only, so a writeback frees its register one cycle later.
  always_comb begin
    raw1         = ISSUE_RS1_USE && is_arch_reg(ISSUE_RS1) && busy_vec[ISSUE_RS1];
    raw2         = ISSUE_RS2_USE && is_arch_reg(ISSUE_RS2) && busy_vec[ISSUE_RS2];
    sat          = ISSUE_RD_WRITE && is_arch_reg(ISSUE_RD) && full_vec[ISSUE_RD];
    hazard       = raw1 || raw2 || sat;
    stall        = ISSUE_VALID && hazard && !FLUSH;
    issue_accept = ISSUE_VALID && !hazard && !MEM_WAIT && !FLUSH;
    inc_en       = issue_accept && ISSUE_RD_WRITE && is_arch_reg(ISSUE_RD);
    dec_en       = WB_VALID && is_arch_reg(WB_RD);
  end

  // The stall counter survives FLUSH. The error flag is a one-cycle echo of any counter underflow.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    err_d = |uf_vec;
  end

  // Performance counter and error flag registers, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  assign ISSUE_ACCEPT  = issue_accept;
  assign STALL         = stall;
  assign BUSY_VEC      = busy_vec;
  assign ERR_UNDERFLOW = err_q;
  assign STALL_CNT     = stall_cnt_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard.
// Directed vectors are checked every cycle against a behavioural pending-write
// model, and hand-computed literal checks pin that model.
module tb_issue_scoreboard;

  localparam int MAX_CNT = 3;

  logic        CLK;
  logic        RST;
  logic        FLUSH;
  logic        MEM_WAIT;
  logic        ISSUE_VALID;
  logic [4:0]  ISSUE_RS1;
  logic        ISSUE_RS1_USE;
  logic [4:0]  ISSUE_RS2;
  logic        ISSUE_RS2_USE;
  logic [4:0]  ISSUE_RD;
  logic        ISSUE_RD_WRITE;
  logic        WB_VALID;
  logic [4:0]  WB_RD;
  logic        ISSUE_ACCEPT;
  logic        STALL;
  logic [31:0] BUSY_VEC;
  logic        ERR_UNDERFLOW;
  logic [31:0] STALL_CNT;

  int checks = 0;
  int errors = 0;

  int          model_cnt [32];
  logic [31:0] model_stall_cnt = '0;
  logic        model_err = 1'b0;
  bit          model_valid = 1'b0;

  issue_scoreboard #(.CNT_W(2), .STALL_CNT_W(32)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .FLUSH          (FLUSH),
    .MEM_WAIT       (MEM_WAIT),
    .ISSUE_VALID    (ISSUE_VALID),
    .ISSUE_RS1      (ISSUE_RS1),
    .ISSUE_RS1_USE  (ISSUE_RS1_USE),
    .ISSUE_RS2      (ISSUE_RS2),
    .ISSUE_RS2_USE  (ISSUE_RS2_USE),
    .ISSUE_RD       (ISSUE_RD),
    .ISSUE_RD_WRITE (ISSUE_RD_WRITE),
    .WB_VALID       (WB_VALID),
    .WB_RD          (WB_RD),
    .ISSUE_ACCEPT   (ISSUE_ACCEPT),
    .STALL          (STALL),
    .BUSY_VEC       (BUSY_VEC),
    .ERR_UNDERFLOW  (ERR_UNDERFLOW),
    .STALL_CNT      (STALL_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // A single comparison, counted whether it passes or fails.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // A source register is a hazard while any write to it is still outstanding.
  // A destination register is a hazard when its pending count is already at the maximum.
  function automatic logic model_hazard();
    logic h;
    h = 1'b0;
    if (ISSUE_RS1_USE && ISSUE_RS1 != 0 && model_cnt[ISSUE_RS1] > 0) h = 1'b1;
    if (ISSUE_RS2_USE && ISSUE_RS2 != 0 && model_cnt[ISSUE_RS2] > 0) h = 1'b1;
    if (ISSUE_RD_WRITE && ISSUE_RD != 0 && model_cnt[ISSUE_RD] == MAX_CNT) h = 1'b1;
    return h;
  endfunction

  function automatic logic model_accept();
    return ISSUE_VALID && !model_hazard() && !MEM_WAIT && !FLUSH;
  endfunction

  function automatic logic model_stall();
    return ISSUE_VALID && model_hazard() && !FLUSH;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = '0;
    for (int r = 1; r < 32; r++) b[r] = (model_cnt[r] != 0);
    return b;
  endfunction

  // Advance the model at each rising edge using the inputs the DUT sees on that edge.
  always @(posedge CLK) begin
    logic acc;
    logic stl;
    int   inc_r;
    int   dec_r;
    acc = model_accept();
    stl = model_stall();
    if (RST) begin
      for (int r = 0; r < 32; r++) model_cnt[r] = 0;
      model_stall_cnt = '0;
      model_err       = 1'b0;
    end else begin
      if (stl) model_stall_cnt = model_stall_cnt + 32'd1;
      model_err = 1'b0;
      if (FLUSH) begin
        for (int r = 0; r < 32; r++) model_cnt[r] = 0;
      end else begin
        inc_r = (acc && ISSUE_RD_WRITE && ISSUE_RD != 0) ? int'(ISSUE_RD) : -1;
        dec_r = (WB_VALID && WB_RD != 0) ? int'(WB_RD) : -1;
        if (!(inc_r >= 0 && inc_r == dec_r)) begin
          if (inc_r >= 0 && model_cnt[inc_r] < MAX_CNT) model_cnt[inc_r]++;
          if (dec_r >= 0) begin
            if (model_cnt[dec_r] == 0) model_err = 1'b1;
            else model_cnt[dec_r]--;
          end
        end
      end
    end
    model_valid = 1'b1;
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge CLK) begin
    if (model_valid) begin
      checkOutput("model_accept", {31'd0, ISSUE_ACCEPT}, {31'd0, model_accept()});
      checkOutput("model_stall", {31'd0, STALL}, {31'd0, model_stall()});
      checkOutput("model_busy", BUSY_VEC, model_busy());
      checkOutput("model_err", {31'd0, ERR_UNDERFLOW}, {31'd0, model_err});
      checkOutput("model_stall_cnt", STALL_CNT, model_stall_cnt);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle's worth of inputs, then let the combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2,
                               input logic [4:0] rd, input logic w,
                               input logic wbv, input logic [4:0] wbrd,
                               input logic fl, input logic mw);
    ISSUE_VALID    = v;
    ISSUE_RS1      = rs1;
    ISSUE_RS1_USE  = u1;
    ISSUE_RS2      = rs2;
    ISSUE_RS2_USE  = u2;
    ISSUE_RD       = rd;
    ISSUE_RD_WRITE = w;
    WB_VALID       = wbv;
    WB_RD          = wbrd;
    FLUSH          = fl;
    MEM_WAIT       = mw;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic issue_wr(input logic [4:0] rd);
    applyStimulus(1, 0, 0, 0, 0, rd, 1, 0, 0, 0, 0);
  endtask

  task automatic wb_only(input logic [4:0] rd);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, rd, 0, 0);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) model_cnt[r] = 0;
    RST = 1'b1;
    idle();
    tick();
    tick();
    RST = 1'b0;

    // Reset state
    idle();
    checkOutput("rst_busy", BUSY_VEC, 32'h0);
    checkOutput("rst_stall_cnt", STALL_CNT, 32'd0);
    checkOutput("rst_err", {31'd0, ERR_UNDERFLOW}, 32'd0);
    checkOutput("rst_accept", {31'd0, ISSUE_ACCEPT}, 32'd0);
    tick();

    // RAW stall on x5, released one cycle after its writeback
    issue_wr(5);
    checkOutput("raw_issue_acc", {31'd0, ISSUE_ACCEPT}, 32'd1);
    tick();
    applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("raw_busy5", BUSY_VEC, 32'h0000_0020);
    checkOutput("raw_stall", {31'd0, STALL}, 32'd1);
    checkOutput("raw_acc0", {31'd0, ISSUE_ACCEPT}, 32'd0);
    tick();
    tick();
    applyStimulus(1, 5, 1, 0, 0, 0, 0, 1, 5, 0, 0);
    checkOutput("raw_wb_nobypass", {31'd0, STALL}, 32'd1);
    tick();
    applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("raw_release", {31'd0, ISSUE_ACCEPT}, 32'd1);
    checkOutput("raw_stall_cnt", STALL_CNT, 32'd3);
    tick();

    // x0 immunity
    issue_wr(0);
    checkOutput("x0_wr_acc", {31'd0, ISSUE_ACCEPT}, 32'd1);
    tick();
    applyStimulus(1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    checkOutput("x0_rd_acc", {31'd0, ISSUE_ACCEPT}, 32'd1);
    checkOutput("x0_busy", BUSY_VEC, 32'h0);
    tick();
    idle();
    checkOutput("x0_no_err", {31'd0, ERR_UNDERFLOW}, 32'd0);
    tick();

    // Saturation and WAW on x7
    for (int k = 0; k < 3; k++) begin
      issue_wr(7);
      tick();
    end
    issue_wr(7);
    checkOutput("sat_busy7", BUSY_VEC, 32'h0000_0080);
    checkOutput("sat_stall", {31'd0, STALL}, 32'd1);
    tick();
    wb_only(7);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 7, 1, 1, 7, 0, 0);
    checkOutput("same_cycle_acc", {31'd0, ISSUE_ACCEPT}, 32'd1);
    tick();
    issue_wr(7);
    checkOutput("net_unchanged_acc", {31'd0, ISSUE_ACCEPT}, 32'd1);
    tick();
    issue_wr(7);
    checkOutput("sat_again", {31'd0, STALL}, 32'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      wb_only(7);
      tick();
    end
    idle();
    checkOutput("sat_drained", BUSY_VEC, 32'h0);
    tick();

    // Simultaneous inc/dec on different registers
    issue_wr(4);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 3, 1, 1, 4, 0, 0);
    checkOutput("incdec_acc", {31'd0, ISSUE_ACCEPT}, 32'd1);
    tick();
    idle();
    checkOutput("incdec_busy", BUSY_VEC, 32'h0000_0008);
    tick();
    wb_only(3);
    tick();

    // FLUSH mid-operation
    issue_wr(10);
    tick();
    issue_wr(10);
    tick();
    issue_wr(11);
    tick();
    applyStimulus(1, 10, 1, 0, 0, 12, 1, 1, 10, 1, 0);
    checkOutput("flush_pre_busy", BUSY_VEC, 32'h0000_0C00);
    checkOutput("flush_acc", {31'd0, ISSUE_ACCEPT}, 32'd0);
    checkOutput("flush_stall", {31'd0, STALL}, 32'd0);
    tick();
    idle();
    checkOutput("flush_busy", BUSY_VEC, 32'h0);
    checkOutput("flush_no_err", {31'd0, ERR_UNDERFLOW}, 32'd0);
    tick();
    wb_only(11);
    tick();
    idle();
    checkOutput("late_wb_err", {31'd0, ERR_UNDERFLOW}, 32'd1);
    tick();
    checkOutput("late_wb_err_pulse", {31'd0, ERR_UNDERFLOW}, 32'd0);

    // MEM_WAIT blocks issue without raising STALL
    applyStimulus(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 1);
    checkOutput("memwait_acc", {31'd0, ISSUE_ACCEPT}, 32'd0);
    checkOutput("memwait_stall", {31'd0, STALL}, 32'd0);
    tick();
    idle();
    checkOutput("memwait_busy", BUSY_VEC, 32'h0);
    tick();

    // Reset asserted mid-stall while an underflow is in progress
    issue_wr(9);
    tick();
    applyStimulus(1, 9, 1, 0, 0, 0, 0, 1, 20, 0, 0);
    tick();
    checkOutput("pre_rst_err", {31'd0, ERR_UNDERFLOW}, 32'd1);
    RST = 1'b1;
    #1;
    tick();
    RST = 1'b0;
    idle();
    checkOutput("post_rst_busy", BUSY_VEC, 32'h0);
    checkOutput("post_rst_stall_cnt", STALL_CNT, 32'd0);
    checkOutput("post_rst_err", {31'd0, ERR_UNDERFLOW}, 32'd0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
